// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the execute-stage branch resolve unit:
// funct3 codes, 2-bit counter encodings, FSM states.
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_e;

  function automatic ctr_e ctr_next(
    input ctr_e c,
    input logic t
  );
    if (t)
      return (c == ST) ? ST : ctr_e'(c + 2'd1);
    else
      return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// 2-bit saturating branch history table.
// Ports: rd_idx/rd_ctr comb read; wr_en/wr_idx/wr_taken update.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_e             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int N = 1 << IDX_W;

  ctr_e mem [N];

  // Read straight from the array: a same-cycle
  // write is not yet visible, so fetch sees the
  // pre-update counter.
  assign rd_ctr = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        mem[i] <= WNT;
    end else if (wr_en) begin
      mem[wr_idx] <= ctr_next(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolve: taken decision, BHT training,
// mispredict redirect + timed flush, branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic        BrUn,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        illegal_br,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int CW =
    (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_e        state;
  logic [CW-1:0] fcnt;
  logic          taken;
  logic          legal_f3;
  logic          resolve;
  logic          do_br;
  logic          do_ill;
  logic          mispred;
  ctr_e          rd_ctr;
  logic          unused_pc;

  assign unused_pc = ^{if_pc[31:IDX_W+2],
                       if_pc[1:0], ex_pc[1:0]};

  assign BrUn = (ex_funct3 == F3_BLTU) |
                (ex_funct3 == F3_BGEU);

  always_comb begin
    taken    = 1'b0;
    legal_f3 = 1'b1;
    unique case (ex_funct3)
      F3_BEQ:          taken = BrEq;
      F3_BNE:          taken = ~BrEq;
      F3_BLT, F3_BLTU: taken = BrLT;
      F3_BGE, F3_BGEU: taken = ~BrLT;
      default:         legal_f3 = 1'b0;
    endcase
    if (ex_is_jump)
      taken = 1'b1;
  end

  // Wrong-path instructions arrive while not IDLE
  // and must leave no trace.
  assign resolve = ex_valid &
                   (ex_is_branch | ex_is_jump) &
                   (state == IDLE);
  assign do_br   = resolve & ex_is_branch &
                   ~ex_is_jump & legal_f3;
  assign do_ill  = resolve & ex_is_branch &
                   ~ex_is_jump & ~legal_f3;
  assign mispred = ((resolve & ex_is_jump) | do_br) &
                   (taken != ex_pred_taken);

  bht_2bit #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (do_br),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign if_pred_taken = rd_ctr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      fcnt           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      illegal_br     <= 1'b0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else begin
      illegal_br     <= do_ill;
      redirect_valid <= 1'b0;
      if (do_br)
        br_count <= br_count + 32'd1;
      if (mispred)
        mispred_count <= mispred_count + 32'd1;
      unique case (state)
        IDLE: begin
          if (mispred) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            redirect_pc    <= taken ? ex_target
                                    : ex_pc + 32'd4;
          end
        end
        REDIRECT: begin
          if (FLUSH_CYC == 1) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            state <= FLUSH;
            fcnt  <= CW'(FLUSH_CYC - 1);
          end
        end
        FLUSH: begin
          fcnt <= fcnt - 1'b1;
          if (fcnt == CW'(1)) begin
            state <= IDLE;
            flush <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the branch comparator's BrLT/BrEq outputs in the pipelined RV32I core.
- Drives the comparator's BrUn select from funct3 and decides taken/not-taken per B-type funct3.
- Trains a small 2-bit branch history table (BHT) that fetch reads, and on a mispredict issues a registered PC redirect followed by a timed wrong-path flush.

Parameters:
- IDX_W, 4, BHT index width; table holds 2^IDX_W 2-bit counters, indexed by pc[IDX_W+1:2].
- FLUSH_CYC, 2, number of cycles the flush is held after a redirect (minimum 1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  fetch PC for BHT lookup
- if_pred_taken  out  1  BHT prediction for if_pc; counter MSB, combinational read
- ex_valid  in  1  execute slot holds a real instruction
- ex_is_branch  in  1  B-type instruction in execute
- ex_is_jump  in  1  JAL/JALR in execute
- ex_funct3  in  3  branch funct3
- ex_pc  in  32  PC of the execute instruction
- ex_target  in  32  computed branch/jump target
- ex_pred_taken  in  1  prediction carried down from fetch
- BrUn  out  1  to comparator; 1 when ex_funct3 is 110 or 111, else 0 (combinational)
- BrEq  in  1  from comparator
- BrLT  in  1  from comparator
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  32  corrected PC
- flush  out  1  kill IF/ID/EX wrong-path contents
- illegal_br  out  1  one-cycle pulse: branch with funct3 010/011 was resolved
- br_count  out  32  resolved conditional branches, wraps at 2^32
- mispred_count  out  32  mispredicts (branches and jumps), wraps at 2^32

Behaviour:
- Reset: all outputs 0; every BHT entry 2'b01 (weakly not-taken); state IDLE; counters 0. Reset is asynchronous and may occur mid-flush; it aborts everything immediately.
- Resolve condition: ex_valid & (ex_is_branch | ex_is_jump) & state==IDLE. In REDIRECT or FLUSH, execute inputs are ignored: no BHT update, no counting.
- Taken decision by funct3:
  - 000: BrEq
  - 001: ~BrEq
  - 100 and 110: BrLT
  - 101 and 111: ~BrLT
  - 010/011: not taken; pulse illegal_br next cycle; no BHT update; not counted.
  - A jump is always taken.
- Mispredict: taken != ex_pred_taken.
- BHT update on a resolved legal branch, at the clock edge: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00. Jumps never update the BHT.
- Read/write collision: an if_pc lookup of the index being written in the same cycle returns the pre-update value.
- br_count increments by 1 per resolved legal branch; mispred_count increments by 1 per mispredict. Both are registered and visible the cycle after resolution.
- FSM:
  - IDLE → REDIRECT on a mispredict.
  - REDIRECT (1 cycle): redirect_valid=1, flush=1, redirect_pc = taken ? ex_target : ex_pc+4 (32-bit, wraps). Load flush counter with FLUSH_CYC-1 and go to FLUSH; if FLUSH_CYC==1, go directly to IDLE.
  - FLUSH: flush=1; decrement counter; on reaching 0, go to IDLE.
  - Total flush width = FLUSH_CYC cycles, including the REDIRECT cycle.
- Latency: resolution in cycle N gives redirect_valid/flush in cycle N+1. A correct prediction produces no output change except the counters.
- Back-to-back: a mispredict arriving the cycle IDLE is re-entered is accepted normally.
- ex_valid=0, or neither ex_is_branch nor ex_is_jump: no action.

Decomposition:
- Shared package: funct3 constants (F3_BEQ..F3_BGEU), 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11), FSM state enum (IDLE, REDIRECT, FLUSH).
- One sub-module, bht_2bit: the counter array with combinational read port, saturating write port, and reset-to-WNT.

Test Plan:
- Reset → if_pred_taken=0 for if_pc=0x0 and 0x3C; redirect_valid=0; flush=0; both counters 0.
- BEQ, BrEq=1, pred=0, ex_pc=0x100, ex_target=0x180:
  - next cycle: redirect_valid=1 with redirect_pc=0x180;
  - flush high for exactly 2 cycles;
  - mispred_count=1; BHT[0] goes 01→10.
- BGEU (funct3=111), BrLT=0, pred=1, ex_pc=0x20: BrUn=1; no redirect; br_count=1; BHT[8] goes 01→10.
- Saturation: same PC, 4 consecutive taken BLT resolutions (spaced so the unit is IDLE) → counter 11 and stays 11; if_pred_taken=1.
- Wrong-path ignore: a mispredicting branch, then a valid mispredicting branch during FLUSH → only one redirect; mispred_count=1.
- funct3=010 with ex_is_branch=1 → illegal_br pulses 1 cycle; no redirect; counters unchanged. Also assert rst_n low mid-FLUSH → flush=0 immediately; BHT back to all 01.
